// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps at most one imem request
// in flight, and hands each fetched word to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  input  logic              id_ready
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;

  logic [ADDR_W-1:0] redirect_aligned;
  logic [ADDR_W-1:0] pc_plus4;
  logic              redirect_lsb_unused;

  // Redirect targets are forced word aligned; the low bits are dropped on purpose.
  assign redirect_aligned    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];
  assign pc_plus4            = pc_q + ADDR_W'(4);

  assign imem_req_valid = (state_q == ST_REQ) && !redirect_valid && !reset;
  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_plus4_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
            if (redirect_valid) pc_d = redirect_aligned;
          end else begin
            if_instr_d    = imem_resp_data;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_plus4;
            if_valid_d    = 1'b1;
            pc_d          = pc_plus4;
            state_d       = ST_HOLD;
          end
        end else if (redirect_valid) begin
          // Request already in flight: remember to discard its response.
          pc_d   = redirect_aligned;
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_d       = redirect_aligned;
          state_d    = ST_REQ;
        end else if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch sequencer that sits downstream of the program counter. It owns the fetch PC and drives the instruction-memory request/response interface. It delivers each fetched instruction, with its PC and PC+4, to the IF/ID boundary over a valid/ready handshake. Branch and jump redirects from later stages flush in-flight fetches and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0
ADDR_W, 32, PC / address width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  ADDR_W  fetch address (word aligned)
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  instruction word returned this cycle
imem_resp_data  input  32  returned instruction word
redirect_valid  input  1  branch/jump taken, single-cycle pulse
redirect_pc  input  ADDR_W  redirect target
if_valid  output  1  instruction available to decode
if_instr  output  32  instruction word
if_pc  output  ADDR_W  PC of if_instr
if_pc_plus4  output  ADDR_W  if_pc + 4, modulo 2^ADDR_W
id_ready  input  1  decode accepts instruction this cycle

Behaviour:
- Reset (sync, active-high, highest priority):
  - pc <= RESET_PC; state <= REQ; drop <= 0.
  - if_valid <= 0; if_instr, if_pc and if_pc_plus4 <= 0.
  - imem_req_valid = 0 while reset is high.
- One outstanding memory request maximum. States are REQ, WAIT and HOLD.
- imem_req_valid = (state==REQ) && !redirect_valid && !reset; imem_req_addr = pc (combinational).
- REQ:
  - redirect_valid -> pc <= {redirect_pc[ADDR_W-1:2],2'b00}; stay REQ; no request issued this cycle.
  - else req_valid && req_ready -> WAIT.
  - imem_resp_valid is ignored in REQ and HOLD.
- WAIT:
  - resp_valid && (drop || redirect_valid) -> response discarded; drop <= 0; state <= REQ. If redirect_valid, also pc <= aligned redirect_pc.
  - resp_valid, no drop, no redirect -> if_instr <= resp_data; if_pc <= pc; if_pc_plus4 <= pc+4; if_valid <= 1; pc <= pc+4; state <= HOLD.
  - redirect_valid without resp_valid -> pc <= aligned redirect_pc; drop <= 1; stay WAIT.
- HOLD:
  - Outputs stable until the handshake completes.
  - redirect_valid -> if_valid <= 0 (flush); pc <= aligned redirect_pc; state <= REQ. Redirect beats id_ready.
  - else id_ready -> if_valid <= 0; state <= REQ.
- Latency and throughput:
  - Request in cycle N, response in N+k: if_valid rises at edge N+k+1.
  - Next request issues the cycle after the id handshake.
  - Peak rate is 1 instruction per 3 cycles with k=1.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 0. Unaligned redirect_pc has bits [1:0] forced to 0.
- Reset during WAIT: a late response arrives in REQ and is ignored. The memory must not return it after re-request ordering breaks; this is a system requirement, not checked here.

Test Plan:
- Reset and first fetch: reset 2 cycles, req_ready=1, resp 1 cycle later with 32'h2010_0005, id_ready=1. Required: req_addr 0 during reset release; if_valid=1 with if_instr=32'h2010_0005, if_pc=0, if_pc_plus4=4; next request addr 4.
- Sequential run: 4 fetches with id_ready=1. Required: if_pc sequence 0,4,8,C; one new if_valid every 3 cycles.
- Back-pressure: id_ready=0 for 5 cycles while in HOLD at pc 8. Required: if_valid, if_instr and if_pc stable; imem_req_valid=0; resume at addr C after id_ready=1.
- Redirect during WAIT: request at 4 accepted, redirect_pc=32'h83 one cycle later, response 2 cycles after the request. Required: response discarded, if_valid stays 0, next request addr 32'h80, then delivers if_pc=80 followed by 84.
- Redirect coincident with response, and redirect in HOLD. Required: no instruction delivered, or if_valid drops next cycle; next request addr = redirect target.
- Wrap and mid-op reset: redirect to 32'hFFFF_FFFC, fetch. Required: if_pc_plus4=0 and next request addr 0. Then reset asserted in WAIT. Required: next request addr RESET_PC, and the stray resp_valid is ignored.
